// File: rtl/mult_switch_mb.sv
// Multi-buffer stationary multiplier switch: NUM_BUF stationary entries, signed multiply, optional local accumulation.
// Issue-to-result latency is MULT_LAT edges; one op per cycle, no backpressure (ops to invalid entries are dropped).
module mult_switch_mb #(
    parameter int IN_DATA_TYPE  = 16,
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_BUF       = 4,
    parameter int MULT_LAT      = 2
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [IN_DATA_TYPE-1:0]      i_data,
    input  logic                         i_stationary,
    input  logic [$clog2(NUM_BUF)-1:0]   i_buf_sel,
    input  logic                         i_acc,
    input  logic                         i_last,
    input  logic                         i_clear,
    output logic                         o_valid,
    output logic [OUT_DATA_TYPE-1:0]     o_data,
    output logic [NUM_BUF-1:0]           o_buf_valid,
    output logic                         o_miss
);

    localparam int TL = MULT_LAT - 1;

    logic signed [IN_DATA_TYPE-1:0]  buf_q [NUM_BUF];
    logic signed [IN_DATA_TYPE-1:0]  a_q;
    logic signed [IN_DATA_TYPE-1:0]  b_q;
    logic [MULT_LAT-1:0]             vld_q;
    logic [MULT_LAT-1:0]             acc_q;
    logic [MULT_LAT-1:0]             last_q;
    logic [OUT_DATA_TYPE-1:0]        acc_r;

    logic signed [OUT_DATA_TYPE-1:0] prod_s0;
    logic signed [OUT_DATA_TYPE-1:0] prod_tail;
    logic [OUT_DATA_TYPE-1:0]        acc_sum;

    logic is_write;
    logic is_strm;
    logic hit;
    logic issue;

    assign is_write = i_valid & i_stationary;
    assign is_strm  = i_valid & ~i_stationary;
    assign hit      = o_buf_valid[i_buf_sel];
    assign issue    = is_strm & hit;

    // Operands are sign-extended before multiplying so the product is exact in OUT width.
    assign prod_s0 = OUT_DATA_TYPE'(a_q) * OUT_DATA_TYPE'(b_q);

    generate
        if (MULT_LAT == 1) begin : g_nodly
            assign prod_tail = prod_s0;
        end else begin : g_dly
            logic signed [OUT_DATA_TYPE-1:0] prod_q [MULT_LAT-1];
            always_ff @(posedge CLK) begin
                prod_q[0] <= prod_s0;
                for (int k = 1; k < MULT_LAT - 1; k++) begin
                    prod_q[k] <= prod_q[k-1];
                end
            end
            assign prod_tail = prod_q[MULT_LAT-2];
        end
    endgenerate

    assign acc_sum = acc_r + prod_tail;

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_q[i] <= '0;
            end
            o_buf_valid <= '0;
            a_q         <= '0;
            b_q         <= '0;
            vld_q       <= '0;
            acc_q       <= '0;
            last_q      <= '0;
            acc_r       <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_miss      <= 1'b0;
        end else if (i_clear) begin
            o_buf_valid <= '0;
            vld_q       <= '0;
            acc_r       <= '0;
            o_miss      <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            if (is_write) begin
                buf_q[i_buf_sel]       <= i_data;
                o_buf_valid[i_buf_sel] <= 1'b1;
            end
            if (is_strm && !hit) begin
                o_miss <= 1'b1;
            end
            // Operands are latched here so a later rewrite of the entry cannot reach an in-flight op.
            if (issue) begin
                a_q       <= i_data;
                b_q       <= buf_q[i_buf_sel];
                acc_q[0]  <= i_acc;
                last_q[0] <= i_last;
            end
            vld_q[0] <= issue;
            for (int k = 1; k < MULT_LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                acc_q[k]  <= acc_q[k-1];
                last_q[k] <= last_q[k-1];
            end

            o_valid <= vld_q[TL] & (~acc_q[TL] | last_q[TL]);
            if (vld_q[TL]) begin
                if (!acc_q[TL]) begin
                    o_data <= prod_tail;
                end else if (!last_q[TL]) begin
                    acc_r <= acc_sum;
                end else begin
                    o_data <= acc_sum;
                    acc_r  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_switch_mb.sv
// Directed bench for mult_switch_mb: per-cycle vector table plus hand sequences for streaming, clear and reset.
module tb_mult_switch_mb;

    logic        CLK;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_stationary;
    logic [1:0]  i_buf_sel;
    logic        i_acc;
    logic        i_last;
    logic        i_clear;
    logic        o_valid;
    logic [31:0] o_data;
    logic [3:0]  o_buf_valid;
    logic        o_miss;

    int total;
    int bad;

    mult_switch_mb #(
        .IN_DATA_TYPE (16),
        .OUT_DATA_TYPE(32),
        .NUM_BUF      (4),
        .MULT_LAT     (2)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_stationary(i_stationary),
        .i_buf_sel   (i_buf_sel),
        .i_acc       (i_acc),
        .i_last      (i_last),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_buf_valid (o_buf_valid),
        .o_miss      (o_miss)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic        st;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        acc;
        logic        last;
        logic        clr;
        logic        evld;
        logic [31:0] edat;
        logic        emiss;
        logic [3:0]  ebv;
    } vec_t;

    function automatic vec_t mk(logic v, logic st, logic [1:0] sel, int dat, logic acc, logic last,
                                logic clr, logic evld, logic [31:0] edat, logic emiss, logic [3:0] ebv);
        vec_t r;
        r.v = v; r.st = st; r.sel = sel; r.dat = dat[15:0]; r.acc = acc; r.last = last; r.clr = clr;
        r.evld = evld; r.edat = edat; r.emiss = emiss; r.ebv = ebv;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic st, input logic [1:0] sel, input logic [15:0] dat,
                        input logic acc, input logic last, input logic clr);
        i_valid = v; i_stationary = st; i_buf_sel = sel; i_data = dat;
        i_acc = acc; i_last = last; i_clear = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[$];
    int   expq[$];
    int   pulses;

    initial begin
        total = 0;
        bad   = 0;

        // v st sel data acc last clr | evld edat miss bufv
        vecs.push_back(mk(1,1,0,     3,0,0,0, 0,0,0,4'b0001));  // 0 buf0=3
        vecs.push_back(mk(1,1,1,    -5,0,0,0, 0,0,0,4'b0011));  // 1 buf1=-5
        vecs.push_back(mk(1,0,0,     7,0,0,0, 0,0,0,4'b0011));  // 2
        vecs.push_back(mk(1,0,1,    -2,0,0,0, 0,0,0,4'b0011));  // 3
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,21,0,4'b0011)); // 4
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,10,0,4'b0011)); // 5
        vecs.push_back(mk(1,0,2,     4,0,0,0, 0,0,1,4'b0011));  // 6 miss
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,1,4'b0011));  // 7
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,1,4'b0011));  // 8
        vecs.push_back(mk(1,1,2,     6,0,0,0, 0,0,1,4'b0111));  // 9 buf2=6
        vecs.push_back(mk(1,0,2,     4,0,0,0, 0,0,1,4'b0111));  // 10
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,1,4'b0111));  // 11
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,24,1,4'b0111)); // 12
        vecs.push_back(mk(1,1,3,     2,0,0,0, 0,0,1,4'b1111));  // 13 buf3=2
        vecs.push_back(mk(1,0,3,     1,1,0,0, 0,0,1,4'b1111));  // 14 group
        vecs.push_back(mk(1,0,3,     2,1,0,0, 0,0,1,4'b1111));  // 15
        vecs.push_back(mk(1,0,3,     3,1,1,0, 0,0,1,4'b1111));  // 16
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,1,4'b1111));  // 17
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,12,1,4'b1111)); // 18
        vecs.push_back(mk(1,0,3,     1,1,0,0, 0,0,1,4'b1111));  // 19 group again
        vecs.push_back(mk(1,0,3,     2,1,0,0, 0,0,1,4'b1111));  // 20
        vecs.push_back(mk(1,0,3,     3,1,1,0, 0,0,1,4'b1111));  // 21
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,1,4'b1111));  // 22
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,12,1,4'b1111)); // 23
        vecs.push_back(mk(1,0,3,     5,1,0,0, 0,0,1,4'b1111));  // 24 open group
        vecs.push_back(mk(1,0,0,     7,0,0,0, 0,0,1,4'b1111));  // 25 interleaved plain op
        vecs.push_back(mk(1,0,3,    -1,1,1,0, 0,0,1,4'b1111));  // 26 close group
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,21,1,4'b1111)); // 27
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,8,1,4'b1111));  // 28
        vecs.push_back(mk(0,0,0,     0,0,0,1, 0,0,0,4'b0000));  // 29 clear
        vecs.push_back(mk(1,1,0,     3,0,0,0, 0,0,0,4'b0001));  // 30 buf0=3
        vecs.push_back(mk(1,0,0,    10,0,0,0, 0,0,0,4'b0001));  // 31
        vecs.push_back(mk(1,1,0,   100,0,0,0, 0,0,0,4'b0001));  // 32 rewrite while in flight
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,30,0,4'b0001)); // 33 old value used
        vecs.push_back(mk(1,0,0,     1,0,0,0, 0,0,0,4'b0001));  // 34
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,0,4'b0001));  // 35
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,100,0,4'b0001));// 36
        vecs.push_back(mk(1,1,1,-32768,0,0,0, 0,0,0,4'b0011));  // 37
        vecs.push_back(mk(1,0,1,-32768,0,0,0, 0,0,0,4'b0011));  // 38
        vecs.push_back(mk(0,0,0,     0,0,0,0, 0,0,0,4'b0011));  // 39
        vecs.push_back(mk(0,0,0,     0,0,0,0, 1,32'h40000000,0,4'b0011)); // 40

        rst = 1'b1;
        i_valid = 0; i_data = 0; i_stationary = 0; i_buf_sel = 0; i_acc = 0; i_last = 0; i_clear = 0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
        chk("rst_valid", 0, {31'd0, o_valid}, 32'd0);
        chk("rst_data", 0, o_data, 32'd0);
        chk("rst_bufv", 0, {28'd0, o_buf_valid}, 32'd0);
        chk("rst_miss", 0, {31'd0, o_miss}, 32'd0);

        for (int r = 0; r < vecs.size(); r++) begin
            step(vecs[r].v, vecs[r].st, vecs[r].sel, vecs[r].dat, vecs[r].acc, vecs[r].last, vecs[r].clr);
            chk("vec_valid", r, {31'd0, o_valid}, {31'd0, vecs[r].evld});
            chk("vec_miss", r, {31'd0, o_miss}, {31'd0, vecs[r].emiss});
            chk("vec_bufv", r, {28'd0, o_buf_valid}, {28'd0, vecs[r].ebv});
            if (vecs[r].evld) chk("vec_data", r, o_data, vecs[r].edat);
        end

        // Back-to-back stream against buf0=100: every op must produce its own pulse in order.
        pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i <= 20) begin
                step(1'b1, 1'b0, 2'd0, 16'(i), 1'b0, 1'b0, 1'b0);
                expq.push_back(100 * i);
            end else begin
                idle();
            end
            if (o_valid) begin
                pulses++;
                if (expq.size() > 0) chk("b2b_data", pulses, o_data, 32'(expq.pop_front()));
                else chk("b2b_extra", pulses, 32'd1, 32'd0);
            end
        end
        chk("b2b_pulses", 0, 32'(pulses), 32'd20);

        // Clear with ops in flight: no results may emerge.
        step(1'b1, 1'b0, 2'd0, 16'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 16'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_bufv", 0, {28'd0, o_buf_valid}, 32'd0);
        chk("clr_valid", 0, {31'd0, o_valid}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("clr_valid", i, {31'd0, o_valid}, 32'd0);
        end

        // Reset with ops in flight and a pending miss.
        step(1'b1, 1'b1, 2'd0, 16'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd1, 16'd9, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_miss", 0, {31'd0, o_miss}, 32'd1);
        step(1'b1, 1'b0, 2'd0, 16'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 16'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mrst_valid", 0, {31'd0, o_valid}, 32'd0);
        chk("mrst_data", 0, o_data, 32'd0);
        chk("mrst_bufv", 0, {28'd0, o_buf_valid}, 32'd0);
        chk("mrst_miss", 0, {31'd0, o_miss}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("mrst_valid", i, {31'd0, o_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
